// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Holds the opcode map, the FSM state enum and the datapath select encodings.
// Pure declarations only; no logic lives here.
package mc_pkg;

  // Opcode map; values are zero-extended to the opcode port width by the user
  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_LW    = 1;
  localparam int unsigned OP_SW    = 2;
  localparam int unsigned OP_BEQ   = 3;
  localparam int unsigned OP_J     = 4;
  localparam int unsigned OP_ADDI  = 5;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WRITE,
    S_MEM_WB,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // pc_source encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_perf_cnt.sv
// Cycle and retired-instruction counters for the multi-cycle control unit.
// Each counter advances on the edge where its increment input is high and wraps modulo 2^CNT_W.
// No backpressure; the increments are qualified by the control FSM.
module mc_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cycle_inc_i,
  input  logic             instr_inc_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  // Next counter values; plain addition wraps naturally at the counter width
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cycle_inc_i) cycle_d = cycle_q + CNT_W'(1);
    if (instr_inc_i) instr_d = instr_q + CNT_W'(1);
  end

  // Counter registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control FSM driving PC, IR, memory-address and ALU-operand selects.
// Instructions take 3-5 cycles; FETCH/MEM_READ/MEM_WRITE stall until mem_ready.
// Illegal opcodes park the FSM in TRAP until reset. Optional counters under MC_PERF_CNT_EN.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_en,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  state_e     state_q, state_d;
  // Remembers lw vs sw from DECODE so MEM_ADDR does not depend on a live opcode
  logic       is_lw_q, is_lw_d;
  logic [1:0] alu_op_raw;

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_lw_d = (opcode == OPCODE_W'(OP_LW));
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) state_d = S_MEM_ADDR;
        else if (opcode == OPCODE_W'(OP_RTYPE)) state_d = S_EXEC_R;
        else if (opcode == OPCODE_W'(OP_ADDI))  state_d = S_EXEC_I;
        else if (opcode == OPCODE_W'(OP_BEQ))   state_d = S_BRANCH;
        else if (opcode == OPCODE_W'(OP_J))     state_d = S_JUMP;
        else                                    state_d = S_TRAP;
      end
      S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_MEM_WB:    state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_RESET;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Moore output decode; only the FETCH write strobes follow mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op_raw    = ALU_ADD;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = SRCB_BOFF;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op_raw = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_I_WB:      reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op_raw    = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_TRAP:      halted = 1'b1;
      default:     ;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_op_raw);
  assign pc_en  = pc_write | (pc_write_cond & zero);

`ifdef MC_PERF_CNT_EN
  logic cycle_inc, instr_inc;
  assign cycle_inc = (state_q != S_RESET) && (state_q != S_TRAP);
  // A retired instruction is a move into FETCH from a final instruction state
  assign instr_inc = (state_d == S_FETCH) &&
                     (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_I_WB, S_BRANCH, S_JUMP});

  mc_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_inc_i (cycle_inc),
    .instr_inc_i (instr_inc),
    .cycle_cnt_o (cycle_cnt),
    .instr_cnt_o (instr_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Expected controls come from an instruction-relative phase model: each instruction
// is walked as its list of phases, with random memory waits, zero flag and opcodes.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    opcode = 4'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, halted;
  logic [1:0]    alu_src_b, pc_source, alu_op;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  multicycle_control #(.OPCODE_W(4), .ALU_OP_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .pc_en(pc_en), .halted(halted),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc_m = 0;
  int instr_m = 0;

  // Phase kinds within an instruction
  localparam int K_RESET = 0, K_FETCH = 1, K_DECODE = 2, K_ADDR = 3, K_RD = 4, K_WR = 5,
                 K_MWB = 6, K_EXR = 7, K_RWB = 8, K_EXI = 9, K_IWB = 10, K_BR = 11,
                 K_J = 12, K_TRAP = 13;

  // Expected control word:
  // {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[2], pc_source[2], alu_op[2], pc_en, halted}
  function automatic logic [17:0] exp_ctrl(int k, logic mr, logic z);
    logic pw = 0, pwc = 0, irw = 0, io = 0, mrd = 0, mwr = 0, rw = 0, rd = 0, m2r = 0;
    logic asa = 0, hlt = 0;
    logic [1:0] asb = 2'd0, pcs = 2'd0, aop = 2'd0;
    case (k)
      K_FETCH:  begin mrd = 1; asb = 2'd1; pw = mr; irw = mr; end
      K_DECODE: asb = 2'd3;
      K_ADDR:   begin asa = 1; asb = 2'd2; end
      K_RD:     begin mrd = 1; io = 1; end
      K_WR:     begin mwr = 1; io = 1; end
      K_MWB:    begin rw = 1; m2r = 1; end
      K_EXR:    begin asa = 1; aop = 2'd2; end
      K_RWB:    begin rw = 1; rd = 1; end
      K_EXI:    begin asa = 1; asb = 2'd2; end
      K_IWB:    rw = 1;
      K_BR:     begin asa = 1; aop = 2'd1; pwc = 1; pcs = 2'd1; end
      K_J:      begin pw = 1; pcs = 2'd2; end
      K_TRAP:   hlt = 1;
      default:  ;
    endcase
    return {pw, pwc, irw, io, mrd, mwr, rw, rd, m2r, asa, asb, pcs, aop, pw | (pwc & z), hlt};
  endfunction

  function automatic logic [17:0] obs_ctrl();
    return {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, pc_en, halted};
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check_all(string tag, logic [17:0] e);
    logic [CW-1:0] ec, ei;
`ifdef MC_PERF_CNT_EN
    ec = cyc_m[CW-1:0];
    ei = instr_m[CW-1:0];
`else
    ec = '0;
    ei = '0;
`endif
    ncmp++;
    assert (obs_ctrl() === e) else begin
      nerr++;
      $error("FAIL %s ctrl: got %b want %b", tag, obs_ctrl(), e);
    end
    ncmp++;
    assert (cycle_cnt === ec) else begin
      nerr++;
      $error("FAIL %s cycle_cnt: got %0d want %0d", tag, cycle_cnt, ec);
    end
    ncmp++;
    assert (instr_cnt === ei) else begin
      nerr++;
      $error("FAIL %s instr_cnt: got %0d want %0d", tag, instr_cnt, ei);
    end
  endtask

  // One clock of a phase: drive, check away from the edge, then advance the model
  task automatic step(int k, logic mr, logic z, bit last, string tag);
    @(negedge clk);
    mem_ready = mr;
    zero = z;
    #1;
    check_all(tag, exp_ctrl(k, mr, z));
    @(posedge clk);
    if (k != K_RESET && k != K_TRAP) cyc_m++;
    if (last && (mr || !(k == K_FETCH || k == K_RD || k == K_WR))) instr_m++;
  endtask

  task automatic mem_phase(int k, bit last, int waits, string tag);
    repeat (waits) step(k, 1'b0, rbit(), last, tag);
    step(k, 1'b1, rbit(), last, tag);
  endtask

  // Assert reset mid-cycle, check immediate clear, then release and check the RESET cycle
  task automatic apply_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    cyc_m = 0;
    instr_m = 0;
    #1;
    check_all(tag, 18'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = rbit();
    zero = rbit();
    #1;
    check_all({tag, "_release"}, 18'd0);
    @(posedge clk);
  endtask

  task automatic run_instr(int op, int fw, int mw);
    opcode = 4'(op);
    mem_phase(K_FETCH, 0, fw, "fetch");
    step(K_DECODE, rbit(), rbit(), 0, "decode");
    case (op)
      0: begin step(K_EXR, rbit(), rbit(), 0, "exec_r"); step(K_RWB, rbit(), rbit(), 1, "r_wb"); end
      1: begin
        step(K_ADDR, rbit(), rbit(), 0, "lw_addr");
        mem_phase(K_RD, 0, mw, "mem_read");
        step(K_MWB, rbit(), rbit(), 1, "mem_wb");
      end
      2: begin step(K_ADDR, rbit(), rbit(), 0, "sw_addr"); mem_phase(K_WR, 1, mw, "mem_write"); end
      3: step(K_BR, rbit(), rbit(), 1, "branch");
      4: step(K_J, rbit(), rbit(), 1, "jump");
      5: begin step(K_EXI, rbit(), rbit(), 0, "exec_i"); step(K_IWB, rbit(), rbit(), 1, "i_wb"); end
      default: ;
    endcase
  endtask

  initial begin
    apply_reset("por");

    // lw with zero-wait memory, followed by the next fetch
    run_instr(1, 0, 0);

    // FETCH stalled three cycles, then an R-type completes
    run_instr(0, 3, 0);

    // beq taken and not taken
    opcode = 4'd3;
    step(K_FETCH, 1'b1, 1'b0, 0, "beq1_fetch");
    step(K_DECODE, 1'b1, 1'b0, 0, "beq1_decode");
    step(K_BR, 1'b1, 1'b1, 1, "beq_zero1");
    step(K_FETCH, 1'b1, 1'b0, 0, "beq2_fetch");
    step(K_DECODE, 1'b1, 1'b1, 0, "beq2_decode");
    step(K_BR, 1'b1, 1'b0, 1, "beq_zero0");

    // Illegal opcode: TRAP for ten cycles, only reset recovers
    opcode = 4'hF;
    step(K_FETCH, 1'b1, 1'b0, 0, "ill_fetch");
    step(K_DECODE, 1'b1, 1'b0, 0, "ill_decode");
    for (int i = 0; i < 10; i++) step(K_TRAP, rbit(), rbit(), 0, "trap_hold");
    opcode = 4'd0;
    apply_reset("trap_recover");
    run_instr(5, 0, 0);

    // Reset pulsed while MEM_WRITE is stalled
    opcode = 4'd2;
    step(K_FETCH, 1'b1, 1'b0, 0, "sw_fetch");
    step(K_DECODE, 1'b1, 1'b0, 0, "sw_decode");
    step(K_ADDR, 1'b1, 1'b0, 0, "sw_addr");
    step(K_WR, 1'b0, 1'b0, 0, "sw_wait");
    step(K_WR, 1'b0, 1'b0, 0, "sw_wait");
    apply_reset("mid_write");
    run_instr(4, 0, 0);

    // Twenty back-to-back R-types from a clean reset; counters wrap at 4 bits
    apply_reset("cnt_reset");
    for (int i = 0; i < 20; i++) run_instr(0, 0, 0);
    step(K_FETCH, 1'b0, 1'b0, 0, "after_20_rtype");

    // Random legal instruction stream with random memory waits
    for (int i = 0; i < 60; i++)
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    step(K_FETCH, 1'b0, 1'b0, 0, "final_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
